// File: rtl/acumulador_resultados_if.sv
// rtl/acumulador_resultados_if.sv - sum input and result output handshakes of the accumulator
interface acumulador_resultados_if #(
    parameter int LARGURA_ENT = 5,
    parameter int LARGURA_ACC = 8
);
    logic                   inicio;
    logic [LARGURA_ENT-1:0] resultado;
    logic                   ent_valid;
    logic                   ent_ready;
    logic [LARGURA_ACC-1:0] soma;
    logic [7:0]             contagem;
    logic                   estouro;
    logic                   sai_valid;
    logic                   sai_ready;

    // Producer/consumer side: drives sums and start, takes results
    modport master (
        output inicio, resultado, ent_valid, sai_ready,
        input  ent_ready, soma, contagem, estouro, sai_valid
    );

    // Accumulator side
    modport slave (
        input  inicio, resultado, ent_valid, sai_ready,
        output ent_ready, soma, contagem, estouro, sai_valid
    );
endinterface

// File: rtl/acumulador_resultados.sv
// rtl/acumulador_resultados.sv - accumulates a burst of adder sums with count and sticky overflow
module acumulador_resultados #(
    parameter int LARGURA_ENT = 5,
    parameter int LARGURA_ACC = 8,
    parameter int N_AMOSTRAS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    acumulador_resultados_if.slave  bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACUMULA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    localparam logic [7:0] N_FIM = 8'(N_AMOSTRAS);

    estado_t                estado_q, estado_n;
    logic [LARGURA_ACC-1:0] soma_q, soma_n;
    logic [7:0]             contagem_q, contagem_n;
    logic                   estouro_q, estouro_n;
    logic                   sai_valid_q, sai_valid_n;

    logic                   transf;
    logic [LARGURA_ACC:0]   soma_ext;
    logic [7:0]             contagem_inc;

    assign transf       = bus.ent_valid && (estado_q == ACUMULA);
    // One extra bit captures the carry-out used for the sticky overflow
    assign soma_ext     = {1'b0, soma_q} + {{(LARGURA_ACC + 1 - LARGURA_ENT){1'b0}}, bus.resultado};
    assign contagem_inc = contagem_q + 8'd1;

    // State and result registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            soma_q      <= '0;
            contagem_q  <= '0;
            estouro_q   <= 1'b0;
            sai_valid_q <= 1'b0;
        end else begin
            estado_q    <= estado_n;
            soma_q      <= soma_n;
            contagem_q  <= contagem_n;
            estouro_q   <= estouro_n;
            sai_valid_q <= sai_valid_n;
        end
    end

    // Next-state and next-result logic; a start always wins over a same-cycle transfer
    always_comb begin
        estado_n   = estado_q;
        soma_n     = soma_q;
        contagem_n = contagem_q;
        estouro_n  = estouro_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.inicio) begin
                    soma_n     = '0;
                    contagem_n = '0;
                    estouro_n  = 1'b0;
                    estado_n   = ACUMULA;
                end
            end
            ACUMULA: begin
                if (bus.inicio) begin
                    // Restart: the sample handshaken this cycle is consumed but dropped
                    soma_n     = '0;
                    contagem_n = '0;
                    estouro_n  = 1'b0;
                end else if (transf) begin
                    soma_n     = soma_ext[LARGURA_ACC-1:0];
                    estouro_n  = estouro_q | soma_ext[LARGURA_ACC];
                    contagem_n = contagem_inc;
                    if (contagem_inc == N_FIM) begin
                        estado_n = PRONTO;
                    end
                end
            end
            PRONTO: begin
                if (bus.sai_ready) begin
                    if (bus.inicio) begin
                        soma_n     = '0;
                        contagem_n = '0;
                        estouro_n  = 1'b0;
                        estado_n   = ACUMULA;
                    end else begin
                        estado_n   = OCIOSO;
                    end
                end
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase

        sai_valid_n = (estado_n == PRONTO);
    end

    assign bus.ent_ready = (estado_q == ACUMULA);
    assign bus.soma      = soma_q;
    assign bus.contagem  = contagem_q;
    assign bus.estouro   = estouro_q;
    assign bus.sai_valid = sai_valid_q;

endmodule

// File: tb/tb_acumulador_resultados.sv
// tb/tb_acumulador_resultados.sv - scoreboard bench for acumulador_resultados
module tb_acumulador_resultados;

    logic clk;
    logic rst_n;

    acumulador_resultados_if #(.LARGURA_ENT(5), .LARGURA_ACC(8)) if0 ();
    acumulador_resultados_if #(.LARGURA_ENT(5), .LARGURA_ACC(8)) if1 ();

    acumulador_resultados #(.LARGURA_ENT(5), .LARGURA_ACC(8), .N_AMOSTRAS(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    acumulador_resultados #(.LARGURA_ENT(5), .LARGURA_ACC(8), .N_AMOSTRAS(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    typedef struct {
        int soma;
        int cont;
        int est;
    } esperado_t;

    esperado_t q0[$];
    esperado_t q1[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nome, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nome, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int s, input int c, input int e);
        esperado_t x;
        x.soma = s; x.cont = c; x.est = e;
        q0.push_back(x);
    endtask

    task automatic send0(input int v, input bit gap);
        if (gap) begin
            if0.ent_valid = 1'b0;
            tick();
        end
        if0.ent_valid = 1'b1;
        if0.resultado = 5'(v);
        for (int t = 0; t < 20 && !if0.ent_ready; t++) tick();
        chk("ent_ready_em_transf", int'(if0.ent_ready), 1);
        tick();
    endtask

    task automatic release0();
        if0.sai_ready = 1'b1;
        tick();
        if0.sai_ready = 1'b0;
        chk("sai_valid_apos_entrega", int'(if0.sai_valid), 0);
    endtask

    // Monitor for the N=4 instance: each accepted result is compared with the queue head
    always @(negedge clk) begin
        esperado_t e;
        if (rst_n && if0.sai_valid && if0.sai_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resultado0_inesperado actual=%0d expected=none", int'(if0.soma));
            end else begin
                e = q0.pop_front();
                chk("soma0", int'(if0.soma), e.soma);
                chk("contagem0", int'(if0.contagem), e.cont);
                chk("estouro0", int'(if0.estouro), e.est);
            end
        end
    end

    // Monitor for the N=16 instance
    always @(negedge clk) begin
        esperado_t e;
        if (rst_n && if1.sai_valid && if1.sai_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resultado1_inesperado actual=%0d expected=none", int'(if1.soma));
            end else begin
                e = q1.pop_front();
                chk("soma1", int'(if1.soma), e.soma);
                chk("contagem1", int'(if1.contagem), e.cont);
                chk("estouro1", int'(if1.estouro), e.est);
            end
        end
    end

    initial begin
        esperado_t x;
        rst_n = 1'b0;
        if0.inicio = 1'b0; if0.resultado = '0; if0.ent_valid = 1'b0; if0.sai_ready = 1'b0;
        if1.inicio = 1'b0; if1.resultado = '0; if1.ent_valid = 1'b0; if1.sai_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("reset_soma", int'(if0.soma), 0);
        chk("reset_contagem", int'(if0.contagem), 0);
        chk("reset_estouro", int'(if0.estouro), 0);
        chk("reset_sai_valid", int'(if0.sai_valid), 0);
        chk("reset_ent_ready", int'(if0.ent_ready), 0);

        // Nominal burst 3,7,12,30
        if0.inicio = 1'b1; tick(); if0.inicio = 1'b0;
        chk("acumula_ent_ready", int'(if0.ent_ready), 1);
        send0(3, 0); send0(7, 0); send0(12, 0); send0(30, 0);
        if0.ent_valid = 1'b0;
        chk("nominal_sai_valid_latencia", int'(if0.sai_valid), 1);
        chk("nominal_ent_ready_pronto", int'(if0.ent_ready), 0);
        push0(52, 4, 0);
        release0();

        // Bubbles and backpressure: 30 x4 with gaps, hold 5 clks, stray inicio ignored
        if0.inicio = 1'b1; tick(); if0.inicio = 1'b0;
        send0(30, 1); send0(30, 1); send0(30, 0); send0(30, 1);
        if0.ent_valid = 1'b0;
        chk("bolhas_sai_valid", int'(if0.sai_valid), 1);
        for (int i = 0; i < 5; i++) begin
            if0.inicio = (i == 2);
            tick();
            chk("pressao_soma_estavel", int'(if0.soma), 120);
            chk("pressao_ent_ready", int'(if0.ent_ready), 0);
            chk("pressao_sai_valid", int'(if0.sai_valid), 1);
        end
        if0.inicio = 1'b0;
        push0(120, 4, 0);
        release0();

        // Overflow on the N=16 instance: 16 x 30 = 480 -> 224, sticky carry
        if1.inicio = 1'b1; tick(); if1.inicio = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if1.ent_valid = 1'b1;
            if1.resultado = 5'd30;
            tick();
        end
        if1.ent_valid = 1'b0;
        chk("estouro_sai_valid", int'(if1.sai_valid), 1);
        x.soma = 224; x.cont = 16; x.est = 1;
        q1.push_back(x);
        if1.sai_ready = 1'b1; tick(); if1.sai_ready = 1'b0;
        chk("estouro_sai_valid_apos", int'(if1.sai_valid), 0);

        // Restart during ACUMULA with a same-cycle transfer of 9
        if0.inicio = 1'b1; tick(); if0.inicio = 1'b0;
        send0(10, 0); send0(11, 0);
        chk("reinicio_contagem_parcial", int'(if0.contagem), 2);
        if0.inicio = 1'b1; if0.ent_valid = 1'b1; if0.resultado = 5'd9;
        tick();
        if0.inicio = 1'b0; if0.ent_valid = 1'b0;
        chk("reinicio_contagem", int'(if0.contagem), 0);
        chk("reinicio_soma", int'(if0.soma), 0);
        chk("reinicio_ent_ready", int'(if0.ent_ready), 1);
        send0(1, 0); send0(1, 0); send0(1, 0); send0(1, 0);
        if0.ent_valid = 1'b0;
        chk("reinicio_sai_valid", int'(if0.sai_valid), 1);
        push0(4, 4, 0);

        // Back-to-back: inicio with sai_ready in PRONTO goes straight to ACUMULA
        if0.sai_ready = 1'b1; if0.inicio = 1'b1;
        tick();
        if0.sai_ready = 1'b0; if0.inicio = 1'b0;
        chk("seguido_ent_ready", int'(if0.ent_ready), 1);
        chk("seguido_sai_valid", int'(if0.sai_valid), 0);
        chk("seguido_soma_zero", int'(if0.soma), 0);
        chk("seguido_contagem_zero", int'(if0.contagem), 0);
        send0(5, 0); send0(5, 0); send0(5, 0); send0(5, 0);
        if0.ent_valid = 1'b0;
        push0(20, 4, 0);
        release0();

        // Asynchronous reset mid-burst, observed before the next edge
        if0.inicio = 1'b1; tick(); if0.inicio = 1'b0;
        send0(6, 0); send0(7, 0);
        if0.ent_valid = 1'b0;
        chk("pre_reset_contagem", int'(if0.contagem), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_soma", int'(if0.soma), 0);
        chk("async_reset_contagem", int'(if0.contagem), 0);
        chk("async_reset_estouro", int'(if0.estouro), 0);
        chk("async_reset_sai_valid", int'(if0.sai_valid), 0);
        chk("async_reset_ent_ready", int'(if0.ent_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("pos_reset_ent_ready", int'(if0.ent_ready), 0);

        chk("fila0_vazia", q0.size(), 0);
        chk("fila1_vazia", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
